adc128s102_responder: RTL and testbench

ADC128S102_RESPONDER -- requirements
Module: adc128s102_responder

---
 rtl/adc128s102_responder.sv | 119 +++++++++++
 tb/tb_adc128s102_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adc128s102_responder.sv
// adc128s102_responder: SPI slave that emulates an ADC128S102, serving 12-bit channel samples framed by cs_n.
module adc128s102_responder #(
    parameter int SYNC_STAGES = 2,
    parameter logic [2:0] RESET_ADDR = 3'b000
) (
    input  logic        clk_128M,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        din,
    input  logic [95:0] ch_data,
    output logic        dout,
    output logic        dout_oe,
    output logic [2:0]  addr_cur,
    output logic        frame_done,
    output logic        frame_abort
);
    typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync, live;
    logic cs_dly, sck_dly, armed;
    logic cs_s, sck_s, din_s, cs_fall, cs_rise, sck_fall, sck_rise;
    logic [15:0] shift_reg, shift_next;
    logic [4:0] bit_cnt, cnt_next;
    logic [2:0] addr_nxt, an_next, ac_next;
    logic done_next, abort_next;
    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign din_s = din_sync[SYNC_STAGES-1];
    assign cs_fall = cs_dly & ~cs_s & armed;
    assign cs_rise = ~cs_dly & cs_s;
    assign sck_fall = sck_dly & ~sck_s;
    assign sck_rise = ~sck_dly & sck_s;
    assign dout_oe = state != IDLE;
    assign dout = dout_oe & shift_reg[15];
    // Synchronize pins; armed requires a genuinely high cs after reset so a low-held cs_n cannot start a frame
    always_ff @(posedge clk_128M) begin
        if (reset) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            din_sync <= '1;
            cs_dly   <= 1'b1;
            sck_dly  <= 1'b1;
            live     <= '0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            cs_dly   <= cs_s;
            sck_dly  <= sck_s;
            live     <= {live[SYNC_STAGES-2:0], 1'b1};
            armed    <= armed | (live[SYNC_STAGES-1] & cs_s);
        end
    end
    // State and datapath registers
    always_ff @(posedge clk_128M) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            addr_nxt    <= '0;
            addr_cur    <= RESET_ADDR;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            bit_cnt     <= cnt_next;
            addr_nxt    <= an_next;
            addr_cur    <= ac_next;
            frame_done  <= done_next;
            frame_abort <= abort_next;
        end
    end
    // Frame sequencing: load on cs fall, shift on sck fall, count and capture address on sck rise
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        an_next    = addr_nxt;
        ac_next    = addr_cur;
        done_next  = 1'b0;
        abort_next = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    shift_next = {4'b0000, ch_data[12*addr_cur +: 12]};
                    cnt_next   = '0;
                    an_next    = '0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort_next = 1'b1;
                end else if (sck_fall) begin
                    shift_next = {shift_reg[14:0], 1'b0};
                end else if (sck_rise) begin
                    cnt_next = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd2) an_next[2] = din_s;
                    if (bit_cnt == 5'd3) an_next[1] = din_s;
                    if (bit_cnt == 5'd4) an_next[0] = din_s;
                    if (bit_cnt == 5'd15) begin
                        ac_next    = addr_nxt;
                        done_next  = 1'b1;
                        state_next = OVERRUN;
                    end
                end
            end
            OVERRUN: begin
                if (cs_rise) state_next = IDLE;
                else if (sck_fall) shift_next = {shift_reg[14:0], 1'b0};
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc128s102_responder.sv
// tb_adc128s102_responder: scoreboard bench driving SPI frames against a behavioural ADC model.
`timescale 1ps/1ps
module tb_adc128s102_responder;
    localparam int HALF_CLK = 3906;
    logic clk_128M = 1'b0;
    logic reset = 1'b1;
    logic cs_n = 1'b1;
    logic sck = 1'b1;
    logic din = 1'b0;
    logic [95:0] ch_data = '0;
    logic dout, dout_oe, frame_done, frame_abort;
    logic [2:0] addr_cur;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int both_cnt = 0;
    logic [15:0] exp_q[$];
    logic [2:0] model_addr = 3'b000;

    adc128s102_responder dut (
        .clk_128M(clk_128M), .reset(reset), .cs_n(cs_n), .sck(sck), .din(din),
        .ch_data(ch_data), .dout(dout), .dout_oe(dout_oe), .addr_cur(addr_cur),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #HALF_CLK clk_128M = ~clk_128M;

    always @(negedge clk_128M) begin
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
        if (frame_done && frame_abort) both_cnt++;
    end

    task automatic sck_half();
        #(31250 + $urandom_range(0, 3000));
    endtask

    task automatic run_frame(input logic [2:0] addr, input int nrise, input bit poke);
        logic [15:0] got, exp;
        int d0, a0, zero_bad, nb;
        exp_q.push_back({4'b0000, ch_data[12*model_addr +: 12]});
        d0 = done_cnt;
        a0 = abort_cnt;
        got = '0;
        zero_bad = 0;
        cs_n = 1'b0;
        sck_half();
        for (int i = 0; i < nrise; i++) begin
            @(negedge clk_128M);
            if (i < 16) got[15-i] = dout;
            else if (dout !== 1'b0) zero_bad++;
            if (i == 16) begin
                total++;
                if (done_cnt - d0 !== 1) begin
                    bad++;
                    $display("FAIL done_at_16: got %0d want 1", done_cnt - d0);
                end
            end
            sck = 1'b0;
            din = (i >= 2 && i <= 4) ? addr[4-i] : 1'($urandom_range(0, 1));
            if (poke && i == 5) ch_data = {$urandom, $urandom, $urandom};
            sck_half();
            sck = 1'b1;
            sck_half();
        end
        @(negedge clk_128M);
        total++;
        if (dout !== 1'b0 && nrise >= 16 || dout_oe !== 1'b1) begin
            bad++;
            $display("FAIL in_frame_tail: dout=%b oe=%b want dout=0 oe=1", dout, dout_oe);
        end
        cs_n = 1'b1;
        sck_half();
        @(negedge clk_128M);
        if (nrise >= 16) model_addr = addr;
        exp = exp_q.pop_front();
        nb = nrise < 16 ? nrise : 16;
        total++;
        if ((got >> (16 - nb)) !== (exp >> (16 - nb))) begin
            bad++;
            $display("FAIL stream: got %h want %h (%0d bits)", got, exp, nb);
        end
        total++;
        if (done_cnt - d0 !== int'(nrise >= 16) || abort_cnt - a0 !== int'(nrise < 16)) begin
            bad++;
            $display("FAIL pulses: done=%0d abort=%0d for %0d rises", done_cnt - d0, abort_cnt - a0, nrise);
        end
        total++;
        if (addr_cur !== model_addr) begin
            bad++;
            $display("FAIL addr_cur: got %0d want %0d", addr_cur, model_addr);
        end
        total++;
        if (dout !== 1'b0 || dout_oe !== 1'b0 || zero_bad != 0) begin
            bad++;
            $display("FAIL idle_out: dout=%b oe=%b overrun_nonzero=%0d want 0 0 0", dout, dout_oe, zero_bad);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_128M);
        total++;
        if (dout !== 1'b0 || dout_oe !== 1'b0 || addr_cur !== 3'd0 || frame_done !== 1'b0 || frame_abort !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: dout=%b oe=%b addr=%0d done=%b abort=%b want 0 0 0 0 0",
                     dout, dout_oe, addr_cur, frame_done, frame_abort);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk_128M);
    endtask

    task automatic test_basic_frames();
        ch_data[11:0] = 12'hA5C;
        run_frame(3'b011, 16, 1'b0);
        ch_data[47:36] = 12'h123;
        run_frame(3'b111, 16, 1'b0);
    endtask

    task automatic test_abort();
        run_frame(3'b101, 9, 1'b0);
    endtask

    task automatic test_overrun();
        run_frame(3'b010, 20, 1'b0);
    endtask

    task automatic test_midframe_data();
        run_frame(3'b110, 16, 1'b1);
    endtask

    task automatic test_midframe_reset();
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_n = 1'b0;
        sck_half();
        for (int i = 0; i < 6; i++) begin
            sck = 1'b0;
            sck_half();
            sck = 1'b1;
            sck_half();
        end
        @(negedge clk_128M);
        reset = 1'b1;
        repeat (4) @(negedge clk_128M);
        model_addr = 3'b000;
        total++;
        if (dout !== 1'b0 || dout_oe !== 1'b0 || addr_cur !== 3'd0) begin
            bad++;
            $display("FAIL midframe_reset: dout=%b oe=%b addr=%0d want 0 0 0", dout, dout_oe, addr_cur);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0;
            sck_half();
            sck = 1'b1;
            sck_half();
        end
        @(negedge clk_128M);
        total++;
        if (dout_oe !== 1'b0 || done_cnt != d0 || abort_cnt != a0) begin
            bad++;
            $display("FAIL held_cs_after_reset: oe=%b done=%0d abort=%0d want 0 0 0", dout_oe, done_cnt - d0, abort_cnt - a0);
        end
        cs_n = 1'b1;
        sck_half();
        run_frame(3'b100, 16, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 250; f++) begin
            ch_data = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) == 0) run_frame(3'($urandom_range(0, 7)), $urandom_range(1, 15), 1'($urandom_range(0, 1)));
            else run_frame(3'($urandom_range(0, 7)), $urandom_range(16, 18), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_exclusive_pulses();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL pulse_overlap: got %0d want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frames();
        test_abort();
        test_overrun();
        test_midframe_data();
        test_midframe_reset();
        test_random();
        test_exclusive_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
